wdt_multi: RTL and testbench
============================

# wdt_multi

Multi-channel watchdog timer, the parametrised successor of the single-channel watchdog on the peripheral command bus. It provides NUM_CH independent watchdogs with CNT_W-bit timeouts, all configured through one valid/ready command port. Timeout events are reported as a queue of channel IDs over a valid/ready interrupt port. Each channel also has a level-sensitive expiry flag and an optional second-stage reset request.

## Interface
- NUM_CH, 4: number of watchdog channels, 1..32.
- CNT_W, 32: width of counters and timeout limits, 4..32.
- GRACE, 16: cycles in EXPIRED before rst_req asserts (only used with WDT_RESET_REQ_EN); 1..2^CNT_W-1.
- CH_W, derived: max(1, $clog2(NUM_CH)).
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted; equals !rst.
- cmd_op  in  2  opcode: 0 ENABLE, 1 DISABLE, 2 KICK, 3 LOAD.
- cmd_ch  in  CH_W  target channel; values >= NUM_CH are accepted and ignored.
- cmd_data  in  CNT_W  new timeout limit; used by LOAD only.
- irq_valid  out  1  an expiry event is presented.
- irq_ready  in  1  sink accepts the event.
- irq_ch  out  CH_W  ID of the channel that expired.
- expired  out  NUM_CH  per-channel level flag, 1 while the channel is in EXPIRED.
- rst_req  out  NUM_CH  per-channel reset request (see Configuration).

## Operation
- Each channel has state IDLE/COUNTING/EXPIRED, a CNT_W-bit counter cnt, a CNT_W-bit limit, and a pending bit.
- A command handshake (cmd_valid & cmd_ready) takes effect at that same clock edge. There is no extra delay cycle.
- ENABLE: IDLE->COUNTING with cnt=0. No effect in COUNTING or EXPIRED.
- DISABLE: any state->IDLE with cnt=0. It does not clear pending or the irq slot.
- KICK: in COUNTING, cnt=0. Ignored in IDLE and EXPIRED; an expired channel must be disabled and re-enabled.
- LOAD: limit=cmd_data in any state. cnt is not modified.
- COUNTING: if cnt >= limit, go to EXPIRED with cnt=0 and pending=1; otherwise cnt=cnt+1.
  - A KICK to the same channel at that edge takes priority: the channel stays COUNTING with cnt=0.
  - A LOAD to a value below cnt makes the channel expire at the next edge (the compare is >=, so cnt never wraps).
- EXPIRED: cnt is the grace counter (see Configuration). expired[i]=1.
- IDLE: cnt held at 0.
- Irq slot: a single output register (irq_valid, irq_ch).
  - When the slot is empty, or is handshaking (irq_valid & irq_ready) this edge, and any pending bit is set: load the lowest-index pending channel into the slot, clear that pending bit, and hold irq_valid=1.
  - When the slot is handshaking and no pending bit is set: irq_valid=0.
  - irq_ch is stable while irq_valid=1 and irq_ready=0.
- A pending bit set and a slot load can occur at the same edge for different channels. Neither event is lost.

## Timing
- Reset values: every channel IDLE, cnt=0, limit=0, pending=0. irq_valid=0, irq_ch=0, expired=0, rst_req=0, cmd_ready=0 while rst=1.
- Expiry latency: with limit=L and ENABLE at edge E0, the channel enters EXPIRED at edge E0+L+1. expired rises after that edge.
- Irq latency: irq_valid rises one edge after the expiry edge. A slot handshake with more events pending gives back-to-back events with irq_valid held at 1.
- limit=0: expires at the edge after ENABLE.
- rst asserted mid-operation: at the next edge everything returns to reset values. Pending events are discarded.

## Configuration
- WDT_RESET_REQ_EN defined:
  - In EXPIRED, cnt increments each cycle and saturates at GRACE.
  - rst_req[i]=1 while channel i is EXPIRED and cnt==GRACE, i.e. GRACE edges after the expiry edge.
  - DISABLE or rst clears rst_req[i] at that edge.
- WDT_RESET_REQ_EN undefined: rst_req is tied to 0, cnt holds 0 in EXPIRED, and no grace logic is built.

## Test plan
- LOAD ch1=5, ENABLE ch1 at edge 0 -> ch1 enters EXPIRED at edge 6. irq_valid=1, irq_ch=1 from edge 7 until handshake. expired[1]=1.
- LOAD ch0=4, ENABLE ch0, KICK ch0 every 3 cycles for 20 cycles -> no expiry. Stop kicking -> expires 5 edges after the last KICK.
- LOAD ch2=3, ENABLE ch2; KICK ch2 on the cycle where cnt==3 -> stays COUNTING with cnt=0. Then LOAD ch2=1 while cnt=3 -> expires at the next edge.
- Channels 3 and 0 expire at the same edge with irq_ready=0 for 4 cycles -> irq_ch=0 is held stable. At the handshake, irq_ch=3 follows back-to-back. The next handshake drops irq_valid.
- With WDT_RESET_REQ_EN and GRACE=16: channel expires at edge E -> rst_req rises after edge E+16. DISABLE -> rst_req and expired clear at the command edge; ENABLE restarts counting from 0.
- Assert rst for 1 cycle with two channels counting and one event pending -> all outputs return to reset values. No irq appears afterwards. cmd_ready=0 during rst.

Source files
------------

// File: rtl/wdt_multi.sv
// wdt_multi: NUM_CH independent watchdog timers behind one valid/ready command port,
// with expiry events queued onto a valid/ready irq port. Define WDT_RESET_REQ_EN for grace-timed rst_req.
module wdt_multi #(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 32,
  parameter int unsigned GRACE  = 16,
  parameter int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]  cmd_data,
  output logic              irq_valid,
  input  logic              irq_ready,
  output logic [CH_W-1:0]   irq_ch,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] rst_req
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } ch_state_e;

  localparam logic [1:0] OP_ENABLE  = 2'd0;
  localparam logic [1:0] OP_DISABLE = 2'd1;
  localparam logic [1:0] OP_KICK    = 2'd2;
  localparam logic [1:0] OP_LOAD    = 2'd3;

`ifdef WDT_RESET_REQ_EN
  localparam logic [CNT_W-1:0] GRACE_C = CNT_W'(GRACE);
`else
  logic [31:0] grace_unused;
  assign grace_unused = GRACE;
`endif

  logic              cmd_fire;
  logic [NUM_CH-1:0] expire_set;

  assign cmd_ready = !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             hit;
    logic             set_ev;

    assign hit = cmd_fire && (cmd_ch == CH_W'(gi));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      limit_d = limit_q;
      set_ev  = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (hit && cmd_op == OP_ENABLE) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          // A kick landing on the expiry edge wins, so the compare uses the pre-LOAD limit.
          if (hit && cmd_op == OP_KICK) begin
            cnt_d = '0;
          end else if (cnt_q >= limit_q) begin
            state_d = ST_EXPIRED;
            cnt_d   = '0;
            set_ev  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_EXPIRED: begin
`ifdef WDT_RESET_REQ_EN
          if (cnt_q < GRACE_C) cnt_d = cnt_q + CNT_W'(1);
`else
          cnt_d = '0;
`endif
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (hit && cmd_op == OP_LOAD) limit_d = cmd_data;
      if (hit && cmd_op == OP_DISABLE) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        set_ev  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        limit_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        limit_q <= limit_d;
      end
    end

    assign expire_set[gi] = set_ev;
    assign expired[gi]    = (state_q == ST_EXPIRED);
`ifdef WDT_RESET_REQ_EN
    assign rst_req[gi]    = (state_q == ST_EXPIRED) && (cnt_q == GRACE_C);
`endif
  end

`ifndef WDT_RESET_REQ_EN
  assign rst_req = '0;
`endif

  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] pick, clr;
  logic              found;
  logic [CH_W-1:0]   sel;
  logic              slot_free;
  logic              irq_valid_q, irq_valid_d;
  logic [CH_W-1:0]   irq_ch_q, irq_ch_d;

  // Scan downwards so the last hit is the lowest-index pending channel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    pick  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found   = 1'b1;
        sel     = CH_W'(i);
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_free   = !irq_valid_q || irq_ready;
    irq_valid_d = irq_valid_q;
    irq_ch_d    = irq_ch_q;
    clr         = '0;
    if (slot_free) begin
      irq_valid_d = found;
      if (found) begin
        irq_ch_d = sel;
        clr      = pick;
      end
    end
    // New expiries are OR-ed in after the clear so an event on the pop edge is never lost.
    pending_d = (pending_q & ~clr) | expire_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_ch_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_ch_q    <= irq_ch_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_ch    = irq_ch_q;

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi: a vector table for the basic expiry/irq flow, then
// hand-written sequences for kicks, LOAD-below-cnt, simultaneous expiry, grace and reset.
module tb_wdt_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int GRACE  = 16;
  localparam int CH_W   = 2;

  localparam logic [1:0] OP_EN   = 2'd0;
  localparam logic [1:0] OP_DIS  = 2'd1;
  localparam logic [1:0] OP_KICK = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [CH_W-1:0]   cmd_ch = '0;
  logic [CNT_W-1:0]  cmd_data = '0;
  logic              irq_valid;
  logic              irq_ready = 1'b0;
  logic [CH_W-1:0]   irq_ch;
  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] rst_req;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GRACE(GRACE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_ch(irq_ch),
    .expired(expired), .rst_req(rst_req)
  );

  typedef struct {
    logic              v;
    logic [1:0]        op;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  data;
    logic              rdy;
    logic              exp_iv;
    logic [CH_W-1:0]   exp_ch;
    logic [NUM_CH-1:0] exp_x;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic v, input logic [1:0] op, input int ch, input int data,
                              input logic rdy, input logic iv, input int ich, input logic [3:0] x);
    vec_t r;
    r.v = v; r.op = op; r.ch = CH_W'(ch); r.data = CNT_W'(data); r.rdy = rdy;
    r.exp_iv = iv; r.exp_ch = CH_W'(ich); r.exp_x = x;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cmd(input logic [1:0] op, input int ch, input int data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = CH_W'(ch);
    cmd_data  = CNT_W'(data);
    tick();
    cmd_valid = 1'b0;
    $display("cmd op=%0d ch=%0d data=%0d -> irq_valid=%0b irq_ch=%0d expired=%b rst_req=%b",
             op, ch, data, irq_valid, irq_ch, expired, rst_req);
  endtask

  logic [NUM_CH-1:0] exp_rr;

  initial begin
`ifdef WDT_RESET_REQ_EN
    exp_rr = 4'b0010;
`else
    exp_rr = 4'b0000;
`endif
    // LOAD ch1=5, ENABLE ch1 at edge 0: expiry at edge 6, irq from edge 7
    tbl[0]  = mk(1'b1, OP_LOAD, 1, 5, 1'b0, 1'b0, 0, 4'b0000);
    tbl[1]  = mk(1'b1, OP_EN,   1, 0, 1'b0, 1'b0, 0, 4'b0000);
    for (int i = 2; i <= 6; i++) tbl[i] = mk(1'b0, OP_EN, 0, 0, 1'b0, 1'b0, 0, 4'b0000);
    tbl[7]  = mk(1'b0, OP_EN,   0, 0, 1'b0, 1'b0, 0, 4'b0010);
    tbl[8]  = mk(1'b0, OP_EN,   0, 0, 1'b0, 1'b1, 1, 4'b0010);
    tbl[9]  = mk(1'b0, OP_EN,   0, 0, 1'b0, 1'b1, 1, 4'b0010);
    tbl[10] = mk(1'b0, OP_EN,   0, 0, 1'b1, 1'b0, 0, 4'b0010);
    tbl[11] = mk(1'b1, OP_DIS,  1, 0, 1'b0, 1'b0, 0, 4'b0000);
    // limit=0 on ch0: expires the edge after ENABLE
    tbl[12] = mk(1'b1, OP_EN,   0, 0, 1'b0, 1'b0, 0, 4'b0000);
    tbl[13] = mk(1'b0, OP_EN,   0, 0, 1'b0, 1'b0, 0, 4'b0001);
    tbl[14] = mk(1'b0, OP_EN,   0, 0, 1'b1, 1'b1, 0, 4'b0001);
    tbl[15] = mk(1'b0, OP_EN,   0, 0, 1'b1, 1'b0, 0, 4'b0001);
    tbl[16] = mk(1'b1, OP_DIS,  0, 0, 1'b0, 1'b0, 0, 4'b0000);

    tick();
    tick();
    check("reset cmd_ready", 32'(cmd_ready), 0);
    check("reset irq_valid", 32'(irq_valid), 0);
    check("reset irq_ch", 32'(irq_ch), 0);
    check("reset expired", 32'(expired), 0);
    check("reset rst_req", 32'(rst_req), 0);
    rst = 1'b0;
    #1;
    check("cmd_ready after reset", 32'(cmd_ready), 1);

    for (int i = 0; i < 17; i++) begin
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_ch    = tbl[i].ch;
      cmd_data  = tbl[i].data;
      irq_ready = tbl[i].rdy;
      tick();
      cmd_valid = 1'b0;
      $display("vec %0d: irq_valid=%0b irq_ch=%0d expired=%b", i, irq_valid, irq_ch, expired);
      check($sformatf("vec%0d irq_valid", i), 32'(irq_valid), 32'(tbl[i].exp_iv));
      check($sformatf("vec%0d expired", i), 32'(expired), 32'(tbl[i].exp_x));
      if (tbl[i].exp_iv) check($sformatf("vec%0d irq_ch", i), 32'(irq_ch), 32'(tbl[i].exp_ch));
    end

    // Kicking ch0 (limit 4) every 3rd cycle keeps it alive; expiry 5 edges after the last kick
    irq_ready = 1'b1;
    cmd(OP_LOAD, 0, 4);
    cmd(OP_EN, 0, 0);
    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 2) cmd(OP_KICK, 0, 0);
      else tick();
      check($sformatf("kick step%0d expired", k), 32'(expired), 0);
    end
    tick();
    check("kick +3 expired", 32'(expired), 0);
    tick();
    check("kick +4 expired", 32'(expired), 0);
    tick();
    check("kick +5 expired", 32'(expired), 32'b0001);
    tick();
    check("kick irq_valid", 32'(irq_valid), 1);
    check("kick irq_ch", 32'(irq_ch), 0);
    tick();
    check("kick irq drained", 32'(irq_valid), 0);
    cmd(OP_DIS, 0, 0);
    check("kick disable", 32'(expired), 0);

    // Kick on the cnt==limit edge wins; LOAD below cnt expires at the following edge
    cmd(OP_LOAD, 2, 3);
    cmd(OP_EN, 2, 0);
    tick();
    tick();
    tick();
    cmd(OP_KICK, 2, 0);
    check("kick at limit expired", 32'(expired), 0);
    tick();
    tick();
    cmd(OP_LOAD, 2, 1);
    check("load edge expired", 32'(expired), 0);
    tick();
    check("load below cnt expired", 32'(expired), 32'b0100);
    tick();
    check("load irq_ch", 32'(irq_ch), 2);
    check("load irq_valid", 32'(irq_valid), 1);
    tick();
    cmd(OP_DIS, 2, 0);

    // ch3 and ch0 expire on the same edge with the sink stalled
    irq_ready = 1'b0;
    cmd(OP_LOAD, 3, 3);
    cmd(OP_LOAD, 0, 2);
    cmd(OP_EN, 3, 0);
    cmd(OP_EN, 0, 0);
    tick();
    tick();
    check("dual pre expired", 32'(expired), 0);
    tick();
    check("dual expired", 32'(expired), 32'b1001);
    check("dual irq_valid not yet", 32'(irq_valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("dual stall%0d irq_valid", k), 32'(irq_valid), 1);
      check($sformatf("dual stall%0d irq_ch", k), 32'(irq_ch), 0);
    end
    irq_ready = 1'b1;
    tick();
    check("dual b2b irq_valid", 32'(irq_valid), 1);
    check("dual b2b irq_ch", 32'(irq_ch), 3);
    tick();
    check("dual drained", 32'(irq_valid), 0);
    cmd(OP_DIS, 0, 0);
    cmd(OP_DIS, 3, 0);

    // Grace stage on ch1 (limit 5): rst_req exactly GRACE edges after expiry when enabled
    cmd(OP_EN, 1, 0);
    repeat (5) tick();
    check("grace pre expired", 32'(expired), 0);
    tick();
    check("grace expired", 32'(expired), 32'b0010);
    for (int j = 1; j <= 16; j++) begin
      tick();
      check($sformatf("grace +%0d rst_req", j), 32'(rst_req), (j == 16) ? 32'(exp_rr) : 32'd0);
    end
    cmd(OP_DIS, 1, 0);
    check("grace disable rst_req", 32'(rst_req), 0);
    check("grace disable expired", 32'(expired), 0);
    cmd(OP_EN, 1, 0);
    repeat (5) tick();
    check("reenable pre expired", 32'(expired), 0);
    tick();
    check("reenable expired", 32'(expired), 32'b0010);
    cmd(OP_DIS, 1, 0);
    tick();
    tick();
    check("reenable drained", 32'(irq_valid), 0);

    // Reset mid-operation: slot busy, one event pending, two channels counting
    irq_ready = 1'b0;
    cmd(OP_LOAD, 3, 0);
    cmd(OP_LOAD, 0, 0);
    cmd(OP_EN, 3, 0);
    cmd(OP_EN, 0, 0);
    tick();
    check("pre-reset irq_ch", 32'(irq_ch), 3);
    check("pre-reset expired", 32'(expired), 32'b1001);
    cmd(OP_LOAD, 1, 10);
    cmd(OP_EN, 1, 0);
    cmd(OP_LOAD, 2, 10);
    cmd(OP_EN, 2, 0);
    rst = 1'b1;
    tick();
    check("mid rst cmd_ready", 32'(cmd_ready), 0);
    check("mid rst irq_valid", 32'(irq_valid), 0);
    check("mid rst irq_ch", 32'(irq_ch), 0);
    check("mid rst expired", 32'(expired), 0);
    check("mid rst rst_req", 32'(rst_req), 0);
    rst = 1'b0;
    irq_ready = 1'b1;
    #1;
    check("post rst cmd_ready", 32'(cmd_ready), 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("post rst%0d outputs", k), 32'({irq_valid, expired}), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
